// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see lsu.sv).
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    // funct3 field positions
    localparam int F3_HALF_BIT     = 0;
    localparam int F3_WORD_BIT     = 1;
    localparam int F3_UNSIGNED_BIT = 2;

    // funct3[1] set means word regardless of funct3[0]
    function automatic size_e lsu_decode_size(input logic [2:0] f3);
        if (f3[F3_WORD_BIT])      return SZ_W;
        else if (f3[F3_HALF_BIT]) return SZ_H;
        else                      return SZ_B;
    endfunction

    function automatic logic lsu_misaligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_H:    return lane[0];
            SZ_W:    return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication/strobes and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  size_e       ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = ld_rdata[8*ld_lane +: 8];
    assign ld_half = ld_rdata[16*ld_lane[1] +: 16];

    // Store data is replicated on every lane; the strobe selects the live one.
    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            SZ_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_lane;
            end
            SZ_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << {st_lane[1], 1'b0};
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load result: pick the addressed lane and extend to 32 bits.
    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access per request on a valid/ready memory bus,
// load results returned through a one-cycle register-file write port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus and report a one-cycle 'misaligned' pulse alongside 'done'.
// Without it, address bits below the access size are ignored.
//
// state  | meaning
// IDLE   | waiting for start
// ACCESS | mem_valid high, waiting for mem_ready
// WB     | done pulse, optional register write
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd,
    output logic              busy,
    output logic              done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              reg_write_control,
    output logic [4:0]        reg_write_select,
    output logic [31:0]       reg_write_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    lsu_state_e        state_q;
    size_e             size_q;
    logic              unsigned_q;
    logic              store_q;
    logic [4:0]        rd_q;
    logic [1:0]        lane_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              wr_ctl_q;
    logic [4:0]        wr_sel_q;
    logic [31:0]       wr_data_q;

    logic [ADDR_W-1:0] addr_d;
    size_e             size_d;
    logic              trap_d;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_data;

    assign addr_d = base + offset;
    assign size_d = lsu_decode_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;
    assign trap_d     = lsu_misaligned(size_d, addr_d[1:0]);
    assign misaligned = misaligned_q;
`else
    assign trap_d = 1'b0;
`endif

    lsu_align u_align (
        .st_size     (size_d),
        .st_lane     (addr_d[1:0]),
        .st_data     (store_data),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_size     (size_q),
        .ld_lane     (lane_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data)
    );

    // Request FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            store_q     <= 1'b0;
            rd_q        <= '0;
            lane_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            wr_ctl_q    <= 1'b0;
            wr_sel_q    <= '0;
            wr_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            wr_ctl_q  <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        size_q     <= size_d;
                        unsigned_q <= funct3[F3_UNSIGNED_BIT];
                        store_q    <= is_store;
                        rd_q       <= rd;
                        lane_q     <= addr_d[1:0];
                        busy_q     <= 1'b1;
                        if (trap_d) begin
                            state_q <= ST_WB;
                            done_q  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misaligned_q <= 1'b1;
`endif
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {addr_d[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= is_store ? st_wdata : 32'd0;
                            mem_wstrb_q <= is_store ? st_wstrb : 4'b0000;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= ST_WB;
                        done_q      <= 1'b1;
                        if (!store_q && rd_q != 5'd0) begin
                            wr_ctl_q  <= 1'b1;
                            wr_sel_q  <= rd_q;
                            wr_data_q <= ld_data;
                        end
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign mem_valid         = mem_valid_q;
    assign mem_addr          = mem_addr_q;
    assign mem_wdata         = mem_wdata_q;
    assign mem_wstrb         = mem_wstrb_q;
    assign reg_write_control = wr_ctl_q;
    assign reg_write_select  = wr_sel_q;
    assign reg_write_data    = wr_data_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus randomized accesses checked
// against a byte-arithmetic reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        reg_write_control;
    logic [4:0]  reg_write_select;
    logic [31:0] reg_write_data;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    // observations of the most recent transaction
    int          obs_valid_cycles;
    int          obs_done_k;
    bit          obs_stable;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_wr;
    logic [4:0]  obs_sel;
    logic [31:0] obs_data;
    logic        obs_mis;
    logic        obs_busy_after;
    bit          obs_extra;

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
    lsu dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .rd(rd),
        .busy(busy), .done(done), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .reg_write_control(reg_write_control), .reg_write_select(reg_write_select),
        .reg_write_data(reg_write_data), .misaligned(misaligned)
    );
`else
    localparam bit TRAP = 1'b0;
    assign misaligned = 1'b0;
    lsu dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .rd(rd),
        .busy(busy), .done(done), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .reg_write_control(reg_write_control), .reg_write_select(reg_write_select),
        .reg_write_data(reg_write_data)
    );
`endif

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a);
        return TRAP && ((a % m_bytes(f3)) != 0);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int n = m_bytes(f3);
        int first = (a % 4) / n * n;
        logic [3:0] s = 4'b0000;
        for (int i = 0; i < n; i++) s[first + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (m_bytes(f3))
            1:       return (sd & 32'hFF) * 32'h01010101;
            2:       return (sd & 32'hFFFF) * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        int n = m_bytes(f3);
        longint unsigned v;
        longint unsigned lim;
        if (n == 4) return rdata;
        lim = 64'd1 << (8 * n);
        v = (longint'(rdata) >> (8 * ((a % 4) / n * n))) % lim;
        if (!f3[2] && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        start = 1'b0; is_store = 1'b0; funct3 = 3'd0; base = '0; offset = '0;
        store_data = '0; rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    endtask

    // Issue one request, respond after waitc stall cycles, collect observations.
    // poke re-pulses start while busy and again in the done cycle.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] b,
                           input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rdi,
                           input logic [31:0] rdata, input int waitc, input bit poke);
        obs_valid_cycles = 0; obs_done_k = -1; obs_stable = 1'b1;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
        obs_wr = 1'b0; obs_sel = '0; obs_data = '0; obs_mis = 1'b0;
        obs_busy_after = 1'b1; obs_extra = 1'b0;
        start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off;
        store_data = sd; rd = rdi;
        @(posedge clk); #1;
        start = 1'b0;
        base = $urandom; offset = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        for (int k = 1; k <= 60; k++) begin
            if (mem_valid) begin
                if (obs_valid_cycles == 0) begin
                    obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end else if (mem_addr !== obs_addr || mem_wdata !== obs_wdata ||
                             mem_wstrb !== obs_wstrb) begin
                    obs_stable = 1'b0;
                end
                obs_valid_cycles++;
                mem_ready = (obs_valid_cycles > waitc);
                mem_rdata = mem_ready ? rdata : $urandom;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            if (poke && (k == 1 || done)) begin
                start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h40; offset = '0; rd = 5'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                obs_done_k = k;
                obs_wr = reg_write_control; obs_sel = reg_write_select;
                obs_data = reg_write_data; obs_mis = misaligned;
                break;
            end
            @(posedge clk); #1;
        end
        if (obs_done_k < 0) begin
            checks++; errors++;
            $display("FAIL timeout: done=%0b required done=1 within 60 cycles", done);
            idle_inputs();
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
            return;
        end
        @(posedge clk); #1;
        idle_inputs();
        obs_busy_after = busy;
        for (int q = 0; q < 4; q++) begin
            if (mem_valid || busy || done || reg_write_control) obs_extra = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({busy, done, mem_valid, reg_write_control, misaligned} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b required 00000",
                               {busy, done, mem_valid, reg_write_control, misaligned});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 ||
            reg_write_select !== 5'd0 || reg_write_data !== 32'd0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b sel=%0d data=%h required all 0",
                               mem_addr, mem_wdata, mem_wstrb, reg_write_select, reg_write_data);
        end
    endtask

    task automatic test_lw();
        run_txn(1'b0, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1'b0);
        checks++;
        if (obs_addr !== 32'h104 || obs_wstrb !== 4'b0000) begin
            errors++; $display("FAIL lw_bus: addr=%h wstrb=%b required 00000104/0000", obs_addr, obs_wstrb);
        end
        checks++;
        if (obs_done_k !== 2) begin
            errors++; $display("FAIL lw_latency: done at N+%0d required N+2", obs_done_k);
        end
        checks++;
        if (obs_wr !== 1'b1 || obs_sel !== 5'd5 || obs_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_write: ctl=%b sel=%0d data=%h required 1/5/deadbeef",
                               obs_wr, obs_sel, obs_data);
        end
        checks++;
        if (obs_busy_after !== 1'b0) begin
            errors++; $display("FAIL lw_busy_n3: busy=%b required 0", obs_busy_after);
        end
    endtask

    task automatic test_lb_lbu();
        run_txn(1'b0, 3'b000, 32'h200, 32'd3, 32'h0, 5'd7, 32'h80123456, 0, 1'b0);
        checks++;
        if (obs_addr !== 32'h200 || obs_data !== 32'hFFFFFF80 || obs_sel !== 5'd7) begin
            errors++; $display("FAIL lb: addr=%h data=%h sel=%0d required 00000200/ffffff80/7",
                               obs_addr, obs_data, obs_sel);
        end
        run_txn(1'b0, 3'b100, 32'h200, 32'd3, 32'h0, 5'd7, 32'h80123456, 0, 1'b0);
        checks++;
        if (obs_addr !== 32'h200 || obs_data !== 32'h00000080 || obs_wr !== 1'b1) begin
            errors++; $display("FAIL lbu: addr=%h data=%h ctl=%b required 00000200/00000080/1",
                               obs_addr, obs_data, obs_wr);
        end
    endtask

    task automatic test_sh_wait();
        run_txn(1'b1, 3'b001, 32'h300, 32'd2, 32'h0000ABCD, 5'd3, 32'h0, 3, 1'b0);
        checks++;
        if (obs_wdata !== 32'hABCDABCD || obs_wstrb !== 4'b1100 || obs_addr !== 32'h300) begin
            errors++; $display("FAIL sh_lanes: wdata=%h wstrb=%b addr=%h required abcdabcd/1100/00000300",
                               obs_wdata, obs_wstrb, obs_addr);
        end
        checks++;
        if (obs_valid_cycles !== 4 || obs_stable !== 1'b1) begin
            errors++; $display("FAIL sh_hold: valid_cycles=%0d stable=%b required 4/1",
                               obs_valid_cycles, obs_stable);
        end
        checks++;
        if (obs_done_k !== 5 || obs_wr !== 1'b0) begin
            errors++; $display("FAIL sh_done: done at N+%0d ctl=%b required N+5/0", obs_done_k, obs_wr);
        end
    endtask

    task automatic test_rd0_busy_start();
        run_txn(1'b0, 3'b010, 32'h500, 32'd0, 32'h0, 5'd0, 32'h12345678, 1, 1'b1);
        checks++;
        if (obs_valid_cycles !== 2 || obs_done_k !== 3 || obs_wr !== 1'b0) begin
            errors++; $display("FAIL rd0: valid_cycles=%0d done at N+%0d ctl=%b required 2/N+3/0",
                               obs_valid_cycles, obs_done_k, obs_wr);
        end
        checks++;
        if (obs_busy_after !== 1'b0 || obs_extra !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: busy=%b extra_activity=%b required 0/0",
                               obs_busy_after, obs_extra);
        end
    endtask

    task automatic test_reset_mid_access();
        bit saw_wr = 1'b0;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h600; offset = '0; rd = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: mem_valid=%b required 1", mem_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid: mem_valid=%b busy=%b done=%b required 0/0/0",
                               mem_valid, busy, done);
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        for (int q = 0; q < 3; q++) begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (reg_write_control || done || busy) saw_wr = 1'b1;
        end
        checks++;
        if (saw_wr !== 1'b0) begin
            errors++; $display("FAIL rst_late_resp: activity=%b required 0", saw_wr);
        end
        idle_inputs();
    endtask

    task automatic test_misalign();
        run_txn(1'b0, 3'b010, 32'h100, 32'd1, 32'h0, 5'd4, 32'hA5A5_1234, 0, 1'b0);
        if (TRAP) begin
            checks++;
            if (obs_valid_cycles !== 0 || obs_done_k !== 1 || obs_mis !== 1'b1 || obs_wr !== 1'b0) begin
                errors++; $display("FAIL misalign_trap: valid_cycles=%0d done at N+%0d mis=%b ctl=%b required 0/N+1/1/0",
                                   obs_valid_cycles, obs_done_k, obs_mis, obs_wr);
            end
        end else begin
            checks++;
            if (obs_addr !== 32'h100 || obs_data !== 32'hA5A51234 || obs_done_k !== 2) begin
                errors++; $display("FAIL misalign_ignored: addr=%h data=%h done at N+%0d required 00000100/a5a51234/N+2",
                                   obs_addr, obs_data, obs_done_k);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        st = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] b = $urandom;
            logic [31:0] off = 32'($signed(12'($urandom)));
            logic [31:0] sd = $urandom;
            logic [4:0]  rdi = 5'($urandom);
            logic [31:0] rdata = $urandom;
            int          waitc = $urandom_range(0, 3);
            logic [31:0] a = b + off;
            bit          trap = m_trap(f3, a);
            bit          exp_wr = !st && rdi != 0 && !trap;
            run_txn(st, f3, b, off, sd, rdi, rdata, waitc, 1'b0);
            if (obs_done_k < 0) continue;
            checks++;
            if (obs_done_k !== (trap ? 1 : waitc + 2) || obs_valid_cycles !== (trap ? 0 : waitc + 1) ||
                obs_mis !== trap || obs_busy_after !== 1'b0) begin
                errors++; $display("FAIL rnd_timing[%0d]: done N+%0d valid=%0d mis=%b busy=%b required N+%0d/%0d/%b/0",
                                   t, obs_done_k, obs_valid_cycles, obs_mis, obs_busy_after,
                                   trap ? 1 : waitc + 2, trap ? 0 : waitc + 1, trap);
            end
            if (trap) continue;
            checks++;
            if (obs_addr !== (a & 32'hFFFF_FFFC) || obs_stable !== 1'b1) begin
                errors++; $display("FAIL rnd_addr[%0d]: addr=%h stable=%b required %h/1",
                                   t, obs_addr, obs_stable, a & 32'hFFFF_FFFC);
            end
            checks++;
            if (obs_wstrb !== (st ? m_wstrb(f3, a) : 4'b0000) ||
                (st && obs_wdata !== m_wdata(f3, sd))) begin
                errors++; $display("FAIL rnd_store[%0d]: wstrb=%b wdata=%h required %b/%h",
                                   t, obs_wstrb, obs_wdata, st ? m_wstrb(f3, a) : 4'b0000, m_wdata(f3, sd));
            end
            checks++;
            if (obs_wr !== exp_wr || (exp_wr && (obs_sel !== rdi || obs_data !== m_load(f3, a, rdata)))) begin
                errors++; $display("FAIL rnd_load[%0d]: ctl=%b sel=%0d data=%h required %b/%0d/%h",
                                   t, obs_wr, obs_sel, obs_data, exp_wr, rdi, m_load(f3, a, rdata));
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_rd0_busy_start();
        test_reset_mid_access();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core. Takes a decoded load or store with its base register (`reg1`), store data (`reg2`), immediate offset and destination index. Runs one access on the native memory valid/ready bus. For loads, returns the aligned, sign- or zero-extended result through a one-cycle write port that drives the register file's `reg_write_control`/`reg_write_select`/`reg_write_data` inputs.

## Interface
- `ADDR_W`, default 32: byte-address width of `mem_addr`, `base` and `offset`.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe. Accepted only when `busy`=0; ignored otherwise.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: [1:0] size (00 byte, 01 half, 1x word); [2] unsigned load (LBU/LHU). [2] is ignored for stores and word loads.
- `base` in ADDR_W: rs1 value.
- `offset` in ADDR_W: sign-extended immediate.
- `store_data` in 32: rs2 value.
- `rd` in 5: load destination.
- `busy` out 1: unit not idle.
- `done` out 1: one-cycle completion pulse.
- `mem_valid` out 1, `mem_ready` in 1: request handshake.
- `mem_addr` out ADDR_W: word-aligned address, [1:0]=0.
- `mem_wdata` out 32: store data, lane-replicated.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_rdata` in 32: valid in the cycle `mem_ready`=1.
- `reg_write_control` out 1, `reg_write_select` out 5, `reg_write_data` out 32: register file write port.
- `misaligned` out 1: fault pulse; exists only with the macro.

## Operation
- FSM states: IDLE, ACCESS, WB.
- IDLE, on `start`:
  - Latch addr = `base`+`offset` (mod 2^ADDR_W), plus size, unsigned, `is_store`, `rd`, `store_data`.
  - Go to ACCESS, or to WB when trapping a misaligned access.
- ACCESS:
  - `mem_valid`=1. `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable until `mem_ready`.
  - On `mem_ready`: capture `mem_rdata` and go to WB.
- WB:
  - `done`=1 for one cycle.
  - For loads with `rd`≠0: `reg_write_control`=1 with `reg_write_select`=`rd`. Loads to x0 and all stores produce no write.
  - Next state IDLE.
- Store lanes:
  - Byte: `mem_wdata`={4{sd[7:0]}}, `mem_wstrb`=0001<<addr[1:0].
  - Half: {2{sd[15:0]}}, `mem_wstrb`=0011<<{addr[1],0}.
  - Word: `mem_wstrb`=1111.
- Load extract: byte = rdata>>(8·addr[1:0]); half = rdata>>(16·addr[1]). Sign-extend from bit 7 or 15, or zero-extend when unsigned.
- `reset` in any state: next edge is IDLE. All outputs return to 0, including `mem_valid`, `done`, `busy`, `reg_write_control`, `misaligned`, addr/data/strobe/select. A response arriving after reset is ignored.

## Timing
- `start` accepted at edge N. ACCESS runs from N+1. If `mem_ready`=1 in that cycle, WB is cycle N+2. `busy` is 0 again in cycle N+3.
- Minimum 3 cycles per access, plus 1 cycle per wait cycle on `mem_ready`.
- `busy` = state≠IDLE and is registered. A `start` in the same cycle that `done`=1 is ignored.
- No bus timeout: ACCESS waits indefinitely.
- `reg_write_data` is registered and valid only while `reg_write_control`=1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half with addr[0]=1, or word with addr[1:0]≠0, skips ACCESS and goes straight to WB.
  - WB then asserts `done`=1 and `misaligned`=1, with no register write and no bus activity.
- Undefined:
  - `misaligned` port absent.
  - The low address bits below the access size are ignored: half uses addr[1] only, word forces addr[1:0] to 0.

## Structure
- `lsu_pkg`: FSM state enum, size enum (SZ_B/SZ_H/SZ_W), funct3 field constants.
- One combinational sub-module, `lsu_align`: store lane replication and strobe generation, plus load extraction and extension. The top module holds the FSM and registers.

## Test plan
- LW: base 0x100, offset 4, rd 5, `mem_rdata`=0xDEADBEEF, `mem_ready` in the first ACCESS cycle.
  - Expect `mem_addr`=0x104 and `mem_wstrb`=0000.
  - Cycle N+2: `reg_write_control`=1, select 5, data 0xDEADBEEF, `done`=1.
- LB vs LBU: addr 0x203, rdata 0x80123456, rd 7.
  - LB writes 0xFFFFFF80.
  - LBU writes 0x00000080.
  - `mem_addr`=0x200 for both.
- SH to 0x302, store_data 0x0000ABCD, `mem_ready` delayed 3 cycles.
  - Expect `mem_wdata`=0xABCDABCD and `mem_wstrb`=1100, held stable for 4 cycles.
  - `done` in the cycle after `mem_ready`; no register write.
- LW with rd=0: full bus transaction, `done`=1, `reg_write_control` stays 0. A `start` pulsed while `busy`=1 produces no second access.
- `reset` asserted mid-ACCESS: next cycle `mem_valid`=0 and `busy`=0. A `mem_ready`/rdata arriving afterwards causes no write.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x101: `mem_valid` is never 1, `misaligned`=`done`=1 at N+1, no write. Without the macro, the same request reads word 0x100.
